// File: rtl/ram_arbiter_2m.sv
// rtl/ram_arbiter_2m.sv - two-master (fetch/data) arbiter for a single-port 32-bit RAM
// Optional round-robin arbitration is enabled by defining RAM_ARB_RR_EN (default: fixed data-over-fetch priority).
module ram_arbiter_2m #(
  parameter logic [31:0] BaseAddr = 32'h0000_0000,
  parameter int unsigned Depth    = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_be_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i
);

  localparam logic [31:0] WinBytes = 32'(4 * Depth);

  logic gnt_instr, gnt_data, gnt_any;
  logic instr_hit, data_hit, win_hit;
  logic owner_q, pend_q, miss_q;
  logic resp_ok;

  // Unsigned wrap makes addresses below BaseAddr miss as well.
  assign instr_hit = (instr_addr_i - BaseAddr) < WinBytes;
  assign data_hit  = (data_addr_i - BaseAddr) < WinBytes;

`ifdef RAM_ARB_RR_EN
  logic last_q;

  always_comb begin
    gnt_instr = 1'b0;
    gnt_data  = 1'b0;
    if (rst_n) begin
      if (instr_req_i && data_req_i) begin
        gnt_data  = ~last_q;
        gnt_instr = last_q;
      end else begin
        gnt_data  = data_req_i;
        gnt_instr = instr_req_i;
      end
    end
  end
`else
  always_comb begin
    gnt_instr = 1'b0;
    gnt_data  = 1'b0;
    if (rst_n) begin
      gnt_data  = data_req_i;
      gnt_instr = instr_req_i & ~data_req_i;
    end
  end
`endif

  assign gnt_any     = gnt_instr | gnt_data;
  assign win_hit     = gnt_data ? data_hit : instr_hit;
  assign instr_gnt_o = gnt_instr;
  assign data_gnt_o  = gnt_data;

  always_comb begin
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;
    ram_addr_o  = 32'h0;
    ram_wdata_o = 32'h0;
    if (gnt_data) begin
      ram_req_o   = data_hit;
      ram_we_o    = data_we_i;
      ram_be_o    = data_be_i;
      ram_addr_o  = data_addr_i;
      ram_wdata_o = data_wdata_i;
    end else if (gnt_instr) begin
      ram_req_o   = instr_hit;
      ram_be_o    = 4'hF;
      ram_addr_o  = instr_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= 1'b0;
      pend_q  <= 1'b0;
      miss_q  <= 1'b0;
`ifdef RAM_ARB_RR_EN
      last_q  <= 1'b0;
`endif
    end else begin
      owner_q <= gnt_data;
      pend_q  <= gnt_any;
      miss_q  <= gnt_any & ~win_hit;
`ifdef RAM_ARB_RR_EN
      if (gnt_any) last_q <= gnt_data;
`endif
    end
  end

  // A response falling due while reset is asserted is dropped.
  assign resp_ok        = rst_n & pend_q;
  assign instr_rvalid_o = resp_ok & ~owner_q;
  assign data_rvalid_o  = resp_ok & owner_q;
  assign instr_err_o    = instr_rvalid_o & miss_q;
  assign data_err_o     = data_rvalid_o & miss_q;
  assign instr_rdata_o  = (instr_rvalid_o && !miss_q) ? ram_rdata_i : 32'h0;
  assign data_rdata_o   = (data_rvalid_o && !miss_q) ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_ram_arbiter_2m.sv
// tb/tb_ram_arbiter_2m.sv - directed self-checking bench for ram_arbiter_2m
module tb_ram_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        preload = 1'b1;
  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = '0;
  logic        data_req = 1'b0, data_we = 1'b0;
  logic [3:0]  data_be = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;

  logic        instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_rdata;
  logic        data_gnt, data_rvalid, data_err;
  logic [31:0] data_rdata;
  logic        ram_req, ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = '0;

  logic        b_instr_gnt, b_instr_rvalid, b_instr_err;
  logic [31:0] b_instr_rdata;
  logic        b_data_gnt, b_data_rvalid, b_data_err;
  logic [31:0] b_data_rdata;
  logic        b_ram_req, b_ram_we;
  logic [3:0]  b_ram_be;
  logic [31:0] b_ram_addr, b_ram_wdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_arbiter_2m #(.BaseAddr(32'h0000_0000), .Depth(128)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_rdata_o(data_rdata), .data_err_o(data_err),
    .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // Second instance with a non-zero base to exercise the below-base wrap.
  ram_arbiter_2m #(.BaseAddr(32'h0000_1000), .Depth(128)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(b_instr_gnt),
    .instr_rvalid_o(b_instr_rvalid), .instr_rdata_o(b_instr_rdata), .instr_err_o(b_instr_err),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_gnt_o(b_data_gnt), .data_rvalid_o(b_data_rvalid),
    .data_rdata_o(b_data_rdata), .data_err_o(b_data_err),
    .ram_req_o(b_ram_req), .ram_we_o(b_ram_we), .ram_be_o(b_ram_be), .ram_addr_o(b_ram_addr),
    .ram_wdata_o(b_ram_wdata), .ram_rdata_i(32'h0)
  );

  logic [31:0] mem [128];

  always_ff @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      mem[4] <= 32'h0;
    end else if (ram_req) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[8:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[8:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rn, input logic ir, input logic [31:0] ia, input logic dr,
                      input logic dw, input logic [3:0] db, input logic [31:0] da,
                      input logic [31:0] dd);
    @(posedge clk);
    #1;
    rst_n = rn; instr_req = ir; instr_addr = ia;
    data_req = dr; data_we = dw; data_be = db; data_addr = da; data_wdata = dd;
    @(negedge clk);
  endtask

  task automatic idle(input logic rn);
    step(rn, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  logic exp_d [4];

  initial begin
    // Reset: requests are ignored while rst_n is low
    step(1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    preload = 1'b0;
    check("rst_instr_gnt", 32'(instr_gnt), 32'h0);
    check("rst_data_gnt", 32'(data_gnt), 32'h0);
    check("rst_ram_req", 32'(ram_req), 32'h0);
    idle(1'b0);
    idle(1'b1);
    check("por_instr_rvalid", 32'(instr_rvalid), 32'h0);
    check("por_data_rvalid", 32'(data_rvalid), 32'h0);
    check("por_instr_rdata", instr_rdata, 32'h0);
    check("por_data_rdata", data_rdata, 32'h0);
    check("idle_ram_we_be", {27'h0, ram_we, ram_be}, 32'h0);

    // Fetch only
    step(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("f_gnt", 32'(instr_gnt), 32'h1);
    check("f_ram_req", 32'(ram_req), 32'h1);
    check("f_ram_we", 32'(ram_we), 32'h0);
    check("f_ram_be", 32'(ram_be), 32'hF);
    check("f_ram_addr", ram_addr, 32'h8);
    idle(1'b1);
    check("f_rvalid", 32'(instr_rvalid), 32'h1);
    check("f_rdata", instr_rdata, 32'hA000_0002);
    check("f_err", 32'(instr_err), 32'h0);
    check("f_data_rvalid", 32'(data_rvalid), 32'h0);
    check("f_data_rdata", data_rdata, 32'h0);

    // Data partial write then read back
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h10, 32'hDEAD_BEEF);
    check("w_gnt", 32'(data_gnt), 32'h1);
    check("w_ram_we", 32'(ram_we), 32'h1);
    check("w_ram_be", 32'(ram_be), 32'h3);
    check("w_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    check("w_rvalid", 32'(data_rvalid), 32'h1);
    check("w_err", 32'(data_err), 32'h0);
    check("r_ram_we", 32'(ram_we), 32'h0);
    idle(1'b1);
    check("r_rvalid", 32'(data_rvalid), 32'h1);
    check("r_rdata", data_rdata, 32'h0000_BEEF);
    check("r_instr_rvalid", 32'(instr_rvalid), 32'h0);

    // Contention from a fresh reset
    idle(1'b0);
`ifdef RAM_ARB_RR_EN
    exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1; exp_d[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 32'hC, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
      check($sformatf("rr_data_gnt%0d", k), 32'(data_gnt), 32'(exp_d[k]));
      check($sformatf("rr_instr_gnt%0d", k), 32'(instr_gnt), 32'(!exp_d[k]));
      if (k > 0) begin
        check($sformatf("rr_data_rv%0d", k), 32'(data_rvalid), 32'(exp_d[k-1]));
        check($sformatf("rr_instr_rv%0d", k), 32'(instr_rvalid), 32'(!exp_d[k-1]));
      end
    end
    idle(1'b1);
    check("rr_instr_rv_last", 32'(instr_rvalid), 32'h1);
    check("rr_instr_rdata_last", instr_rdata, 32'hA000_0003);
`else
    exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1; exp_d[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 32'hC, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
      check($sformatf("fp_data_gnt%0d", k), 32'(data_gnt), 32'(exp_d[k]));
      check($sformatf("fp_instr_gnt%0d", k), 32'(instr_gnt), 32'h0);
      if (k > 0) check($sformatf("fp_data_rv%0d", k), 32'(data_rvalid), 32'h1);
    end
    step(1'b1, 1'b1, 32'hC, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("fp_instr_gnt_drop", 32'(instr_gnt), 32'h1);
    check("fp_data_rv_drop", 32'(data_rvalid), 32'h1);
    check("fp_data_rdata_drop", data_rdata, 32'hA000_0005);
    idle(1'b1);
    check("fp_instr_rv", 32'(instr_rvalid), 32'h1);
    check("fp_instr_rdata", instr_rdata, 32'hA000_0003);
`endif

    // Window edges
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h1FC, 32'h0);
    check("top_ram_req", 32'(ram_req), 32'h1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
    check("top_err", 32'(data_err), 32'h0);
    check("top_rdata", data_rdata, 32'hA000_007F);
    check("oor_gnt", 32'(data_gnt), 32'h1);
    check("oor_ram_req", 32'(ram_req), 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'hFFC, 32'h0);
    check("oor_rvalid", 32'(data_rvalid), 32'h1);
    check("oor_err", 32'(data_err), 32'h1);
    check("oor_rdata", data_rdata, 32'h0);
    check("b_below_gnt", 32'(b_data_gnt), 32'h1);
    check("b_below_ram_req", 32'(b_ram_req), 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0);
    check("b_below_rvalid", 32'(b_data_rvalid), 32'h1);
    check("b_below_err", 32'(b_data_err), 32'h1);
    check("b_base_ram_req", 32'(b_ram_req), 32'h1);
    check("b_base_ram_addr", b_ram_addr, 32'h1000);
    idle(1'b1);
    check("b_base_err", 32'(b_data_err), 32'h0);
    check("b_instr_rvalid", 32'(b_instr_rvalid), 32'h0);

    // Reset the cycle after a grant drops the response
    step(1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("mr_gnt", 32'(instr_gnt), 32'h1);
    idle(1'b0);
    check("mr_instr_rvalid", 32'(instr_rvalid), 32'h0);
    check("mr_data_rvalid", 32'(data_rvalid), 32'h0);
    step(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("mr_post_gnt", 32'(instr_gnt), 32'h1);
    check("mr_post_ram_req", 32'(ram_req), 32'h1);
    idle(1'b1);
    check("mr_post_rvalid", 32'(instr_rvalid), 32'h1);
    check("mr_post_rdata", instr_rdata, 32'hA000_0000);
    check("mr_post_err", 32'(instr_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter_2m.md
# ram_arbiter_2m

Two-master arbiter that shares the single-port 32-bit on-chip RAM between the Ibex instruction-fetch port and the Ibex data port. It sits between the core and the RAM and grants at most one access per cycle. It forwards the winning request to the RAM, remembers who owns the in-flight access, and routes the one-cycle-later response back to that owner. It also decodes the RAM address window and returns an error response for out-of-range accesses without touching the RAM.

## Interface
- BaseAddr, 32'h0000_0000, byte base address of the RAM window (4-byte aligned)
- Depth, 128, RAM size in 32-bit words; window = [BaseAddr, BaseAddr + 4*Depth)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- instr_req_i  in  1  fetch request (read-only master)
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  fetch request accepted this cycle
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch read data
- instr_err_o  out  1  fetch error, qualified by instr_rvalid_o
- data_req_i  in  1  data request
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_addr_i  in  32  data byte address
- data_wdata_i  in  32  write data
- data_gnt_o / data_rvalid_o / data_rdata_o / data_err_o  out  1/1/32/1  as for the instruction port
- ram_req_o  out  1  RAM request
- ram_we_o  out  1  RAM write enable
- ram_be_o  out  4  RAM byte enables
- ram_addr_o  out  32  RAM byte address, passed through unmodified (RAM indexes addr[Aw+1:2])
- ram_wdata_o  out  32  RAM write data
- ram_rdata_i  in  32  RAM read data, valid the cycle after ram_req_o

## Operation
- Arbitration is combinational within a cycle. It is evaluated only when rst_n = 1. While rst_n = 0, all gnt_o and ram_req_o outputs are 0.
- Exactly one master is granted per cycle. gnt_o is asserted in the same cycle as the winning req_i. A losing master keeps req_i high and its address/data stable until granted, per the Ibex protocol.
- Window hit: (addr - BaseAddr) < 4*Depth, computed as a 32-bit unsigned subtraction so that an address below BaseAddr wraps and misses.
- Granted and hit: ram_req_o = 1 and address/be/wdata come from the winner.
  - ram_we_o = data_we_i for the data master, 0 for the fetch master.
  - ram_be_o = 4'hF for the fetch master.
- Granted and miss: the request is still granted, but ram_req_o = 0.
- No grant: ram_req_o = 0; ram_we_o = 0 and ram_be_o = 0.
- Response pipeline registers, all captured each cycle:
  - owner_q: 0 = instr, 1 = data.
  - pend_q: a grant occurred.
  - miss_q: the granted access was out of range.
- Cycle after a grant, on the owner only:
  - rvalid_o = 1.
  - err_o = miss_q.
  - rdata_o = ram_rdata_i on a hit, 32'h0 on a miss.
- The non-owner sees rvalid_o = 0 and rdata_o = 0. err_o is 0 whenever rvalid_o is 0.
- Writes also produce rvalid; the rdata returned on a write is don't-care for the master.
- Back-to-back grants: a new grant in cycle N+1 coexists with the response to the cycle-N grant. There is no bubble, so throughput is 1 access/cycle.
- Reset mid-operation: a response due in the cycle after rst_n falls is dropped. Masters are reset together with the arbiter.

## Timing
- Reset values: owner_q = 0, pend_q = 0, miss_q = 0, last_q = 0 (instr). All rvalid_o/err_o = 0 and all rdata_o = 0 on the first cycle after reset.
- Request-to-grant latency: 0 cycles when uncontended.
- Grant-to-rvalid latency: exactly 1 cycle, for both hits and misses.
- Contended wait: at most 1 cycle with round-robin enabled. With fixed priority, fetch can wait indefinitely under continuous data traffic (accepted).

## Configuration
- RAM_ARB_RR_EN defined: round-robin. When both masters request, the master not equal to last_q wins. last_q updates to the winner on every grant, contended or not.
- RAM_ARB_RR_EN undefined: fixed priority, data over instr. last_q is not implemented.

## Test plan
- Fetch only: instr_req_i = 1, addr 0x8 for one cycle → instr_gnt_o = 1 that cycle, ram_req_o = 1 with ram_we_o = 0 and ram_be_o = F, then instr_rvalid_o = 1 with instr_rdata_o = RAM word 2 and instr_err_o = 0.
- Data write then read: write addr 0x10, be = 4'b0011, wdata 0xDEADBEEF, then read 0x10 (preloaded 0) → read returns 0x0000BEEF on data_rvalid_o one cycle after the read grant.
- Contention with RAM_ARB_RR_EN: both masters request continuously for 4 cycles from reset → grants alternate data, instr, data, instr; each rvalid is routed to the matching master one cycle later.
- Contention without the macro: both request for 3 cycles → data granted all 3 cycles, instr_gnt_o = 0 throughout, and instr is granted in the cycle data_req_i drops.
- Out of range: Depth = 128, data read at 0x200 → data_gnt_o = 1, ram_req_o = 0, next cycle data_rvalid_o = 1, data_err_o = 1, data_rdata_o = 0. An address of BaseAddr − 4 (BaseAddr = 0x1000) also errors.
- Reset mid-transfer: assert rst_n = 0 in the cycle after a grant → no rvalid on either port that cycle. After release, a fetch to 0x0 completes normally.
